// File: rtl/mem_bus_ctrl_if.sv
// Control-unit / memory handshake bundle for mem_bus_ctrl.
interface mem_bus_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
);
  // Control-unit side
  logic                  req;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0] wdata_in;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] rdata_out;

  // RAM side
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_re;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Requester / RAM environment view
  modport master (
    output req, wr, addr_in, wdata_in, mem_rdata,
    input  busy, done, rdata_out, mem_addr, mem_wdata, mem_re, mem_we
  );

  // Controller view
  modport slave (
    input  req, wr, addr_in, wdata_in, mem_rdata,
    output busy, done, rdata_out, mem_addr, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Multi-cycle read/write controller between the control unit and a synchronous RAM.
// Every output is driven straight from a flop; the async clear drops the strobes at once.
module mem_bus_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           clr,
  mem_bus_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  re_q, re_d;
  logic                  we_q, we_d;

  // Next-state, latches and the flop-driven output strobes for the next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          wr_d    = bus.wr;
          addr_d  = bus.addr_in;
          wdata_d = bus.wdata_in;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!wr_q) begin
            rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    re_d   = (state_d == ACCESS) && !wr_d;
    we_d   = (state_d == ACCESS) &&  wr_d;
  end

  // State, latches and output flops; clr clears everything immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      re_q    <= re_d;
      we_q    <= we_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rdata_out = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_re    = re_q;
  assign bus.mem_we    = we_q;

endmodule
